lcd_ctrl: RTL
=============

# lcd_ctrl

- Converts the 32-bit LCD I/O register written by the load/store unit (0x1000_4xxx) into HD44780-style character-LCD pin timing.
- Sits directly downstream of the LSU: its `i_lcd` input connects to the LSU's `o_io_lcd` output, and its outputs drive the board LCD pins.
- Detects each new command in the register, sequences setup/enable/hold/execute delays with a single state machine, and buffers one pending command.

## Interface
Parameters:
- SETUP_CYC, default 4: cycles RS/DATA are stable before EN rises.
- PULSE_CYC, default 25: EN high width in cycles (500 ns at 50 MHz).
- HOLD_CYC, default 4: cycles RS/DATA are held after EN falls.
- EXEC_CYC, default 2000: normal command execution wait (40 µs).
- LONG_EXEC_CYC, default 82000: clear/home execution wait (1.64 ms).
- POWERUP_CYC, default 2000000: post-reset wait before the first command (40 ms).

Ports (reset is synchronous and active-low):
- i_clk, input, 1: clock.
- i_reset, input, 1: synchronous active-low reset.
- i_lcd, input, 32: LCD register. Field layout:
  - [31] ON
  - [30] BLON
  - [12] SEQ toggle
  - [10] RS
  - [9:8] ignored
  - [7:0] DATA
- o_lcd_on, output, 1: registered copy of i_lcd[31].
- o_lcd_blon, output, 1: registered copy of i_lcd[30].
- o_lcd_rs, output, 1: register select for the active command.
- o_lcd_rw, output, 1: constant 0 (write-only).
- o_lcd_en, output, 1: enable strobe.
- o_lcd_data, output, 8: data bus for the active command.
- o_busy, output, 1: high if state≠IDLE or a command is pending.
- o_overrun, output, 1: sticky; set when a pending command is overwritten.

## Operation
- **Command key:** {SEQ, RS, DATA} = i_lcd[12], [10], [7:0].
  - The block registers the previous key every cycle, including when ON=0.
  - Detect = (key ≠ previous key) && i_lcd[31].
  - Software toggles SEQ to reissue an identical command.
- **Pending buffer:** 1-deep, holding {RS, DATA}.
  - A detect writes the buffer and sets pend_v.
  - If pend_v=1 and the FSM does not consume the buffer in that cycle, the new command overwrites it (last wins) and o_overrun is set.
- **FSM states:** INIT, IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter, width $clog2(max parameter + 1).
  - INIT → IDLE after POWERUP_CYC cycles. Detects during INIT are buffered.
  - IDLE with pend_v → SETUP. On this transition, load o_lcd_rs/o_lcd_data from the buffer and clear pend_v.
  - SETUP: SETUP_CYC cycles, then PULSE.
  - PULSE: o_lcd_en=1 for PULSE_CYC cycles, then HOLD.
  - HOLD: o_lcd_en=0 for HOLD_CYC cycles; RS/DATA unchanged; then WAIT.
  - WAIT: LONG_EXEC_CYC if RS=0 and DATA ∈ {0x01, 0x02, 0x03}, otherwise EXEC_CYC; then IDLE.
- **Same-cycle events:**
  - A detect in the cycle the FSM consumes pend_v leaves pend_v=1 holding the new command, with no overrun.
  - A detect in the cycle WAIT exits is buffered normally.
- **ON falls to 0 (any state except INIT):** FSM → IDLE next cycle, o_lcd_en=0, pend_v cleared. INIT is not re-entered.
- **Reset (i_reset=0 at a clock edge):** state=INIT, counter=POWERUP_CYC, pend_v=0, previous key=0.
  - All outputs go to 0 on that edge, including o_overrun.
  - o_busy=1 while in INIT.

## Timing
- o_lcd_on/o_lcd_blon: 1-cycle latency from i_lcd.
- Detect is registered: i_lcd changes before edge N → pend_v=1 after edge N.
- If IDLE, SETUP is entered at edge N+1. o_lcd_rs/o_lcd_data are valid from N+1.
- EN rises at edge N+1+SETUP_CYC and falls at edge N+1+SETUP_CYC+PULSE_CYC.
- IDLE is re-entered at edge N+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait.
- Back-to-back: a command pending on WAIT exit enters SETUP one cycle after IDLE is reached.
- o_lcd_en is glitch-free (driven from a register); it is never high outside PULSE.
- RS/DATA never change between SETUP entry and HOLD exit.

## Test plan
Directed tests use SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, EXEC_CYC=5, LONG_EXEC_CYC=10, POWERUP_CYC=8.

- **Power-up:** reset, then i_lcd=0x8000_0441 at cycle 1 → o_busy=1 through INIT; EN high for exactly 3 cycles starting 8+1+2 cycles after reset release; RS=1, DATA=0x41; o_overrun=0.
- **Clear command:** i_lcd=0x8000_0001 with FSM idle → WAIT lasts 10 cycles; then write 0x8000_0038 → WAIT lasts 5 cycles.
- **Repeat via SEQ:** write 0x8000_0441, then 0x8000_1441 → two EN pulses, both with DATA=0x41; rewriting 0x8000_1441 unchanged → no pulse.
- **Overrun:** during PULSE, write 0x8000_0431 then 0x8000_0432 → o_overrun=1; only 0x32 is issued after the current command.
- **ON gating and abort:** i_lcd=0x0000_0441 → no EN pulse, o_lcd_on=0; mid-PULSE change to ON=0 → EN=0 next cycle, o_busy=0.
- **Mid-operation reset:** i_reset=0 during WAIT → all outputs 0 next edge; after release, INIT lasts 8 cycles before any EN pulse.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns the memory-mapped LCD I/O register into HD44780-style
// character-LCD pin timing. A new command is a change of {SEQ, RS, DATA}
// while ON=1; one command can wait in a pending buffer while another runs.
module lcd_ctrl #(
  parameter int SETUP_CYC     = 4,
  parameter int PULSE_CYC     = 25,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int POWERUP_CYC   = 2000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int DATA_W = 8;
  localparam int KEY_W  = DATA_W + 2;

  function automatic int max_cyc();
    int m;
    m = SETUP_CYC;
    if (PULSE_CYC > m)     m = PULSE_CYC;
    if (HOLD_CYC > m)      m = HOLD_CYC;
    if (EXEC_CYC > m)      m = EXEC_CYC;
    if (LONG_EXEC_CYC > m) m = LONG_EXEC_CYC;
    if (POWERUP_CYC > m)   m = POWERUP_CYC;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max_cyc() + 1);

  // Clear-display (0x01) and return-home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [DATA_W-1:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    prev_key;
  logic                pend_v;
  logic                pend_rs;
  logic [DATA_W-1:0]   pend_data;

  logic [KEY_W-1:0]    key;
  logic                detect;
  logic                abort;
  logic                consume;
  logic                cnt_last;
  logic                unused_bits;

  assign key      = {i_lcd[12], i_lcd[10], i_lcd[7:0]};
  assign detect   = (key != prev_key) && i_lcd[31];
  // Dropping ON kills the current command everywhere except during power-up.
  assign abort    = !i_lcd[31] && (state != ST_INIT);
  assign consume  = (state == ST_IDLE) && pend_v && !abort;
  assign cnt_last = (cnt <= CNT_W'(1));

  assign unused_bits = ^{i_lcd[29:13], i_lcd[11], i_lcd[9:8]};

  assign o_lcd_rw = 1'b0;
  assign o_busy   = (state != ST_IDLE) || pend_v;

  // Power and backlight pins are plain registered copies of the register bits.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_lcd_on   <= 1'b0;
      o_lcd_blon <= 1'b0;
    end else begin
      o_lcd_on   <= i_lcd[31];
      o_lcd_blon <= i_lcd[30];
    end
  end

  // Command detection, pending-valid flag and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      prev_key  <= '0;
      pend_v    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      prev_key <= key;
      if (abort) begin
        pend_v <= 1'b0;
      end else if (detect) begin
        // A detect while the FSM takes the old entry just refills the buffer.
        pend_v <= 1'b1;
        if (pend_v && !consume) begin
          o_overrun <= 1'b1;
        end
      end else if (consume) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Pending command payload; only meaningful while pend_v is set.
  always_ff @(posedge i_clk) begin
    if (detect) begin
      pend_rs   <= i_lcd[10];
      pend_data <= i_lcd[7:0];
    end
  end

  // Sequencer: power-up wait, then setup / enable / hold / execute per command.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= ST_INIT;
      cnt        <= CNT_W'(POWERUP_CYC);
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      o_lcd_en <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt_last) state <= ST_IDLE;
          else          cnt   <= cnt - CNT_W'(1);
        end
        ST_IDLE: begin
          if (pend_v) begin
            state      <= ST_SETUP;
            cnt        <= CNT_W'(SETUP_CYC);
            o_lcd_rs   <= pend_rs;
            o_lcd_data <= pend_data;
          end
        end
        ST_SETUP: begin
          if (cnt_last) begin
            state    <= ST_PULSE;
            cnt      <= CNT_W'(PULSE_CYC);
            o_lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_last) begin
            state    <= ST_HOLD;
            cnt      <= CNT_W'(HOLD_CYC);
            o_lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_last) begin
            state <= ST_WAIT;
            cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? CNT_W'(LONG_EXEC_CYC)
                                                       : CNT_W'(EXEC_CYC);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_last) state <= ST_IDLE;
          else          cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state    <= ST_IDLE;
          o_lcd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
